// File: rtl/serial_to_byte_if.sv
// Bus between a serial bit source and serial_to_byte (the word assembler).
// The parity_err signal exists only when SERIAL_TO_BYTE_PARITY_EN is defined.
interface serial_to_byte_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             bit_in;
  logic             bit_valid;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
`ifdef SERIAL_TO_BYTE_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output bit_in,
    output bit_valid,
    output flush,
    input  data_out,
    input  data_valid,
    input  busy,
`ifdef SERIAL_TO_BYTE_PARITY_EN
    input  parity_err,
`endif
    input  bit_count
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  flush,
    output data_out,
    output data_valid,
    output busy,
`ifdef SERIAL_TO_BYTE_PARITY_EN
    output parity_err,
`endif
    output bit_count
  );
endinterface

// File: rtl/serial_to_byte.sv
// LSB-first serial-to-parallel word assembler with a one-cycle valid strobe.
// Optional even-parity bit after each word: define SERIAL_TO_BYTE_PARITY_EN.
module serial_to_byte #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  serial_to_byte_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_busy;
`ifdef SERIAL_TO_BYTE_PARITY_EN
  logic             r_perr;
`endif

  logic             w_last;
  logic [WIDTH-1:0] w_shift_nxt;

  // New bits enter at the MSB so the first-received bit lands in bit 0.
  assign w_shift_nxt = {bus.bit_in, r_shift[WIDTH-1:1]};
  assign w_last      = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SERIAL_TO_BYTE_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (bus.flush) begin
        // Abort wins over a simultaneous bit; data_out and parity_err keep their values.
        r_state <= S_IDLE;
        r_shift <= '0;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (bus.bit_valid) begin
        case (r_state)
          S_IDLE, S_COLLECT: begin
            r_shift <= w_shift_nxt;
            if (w_last) begin
`ifdef SERIAL_TO_BYTE_PARITY_EN
              r_state <= S_PARITY;
              r_count <= CW'(WIDTH);
              r_busy  <= 1'b1;
`else
              r_data  <= w_shift_nxt;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_count <= '0;
              r_busy  <= 1'b0;
`endif
            end else begin
              r_state <= S_COLLECT;
              r_count <= r_count + CW'(1);
              r_busy  <= 1'b1;
            end
          end
          S_PARITY: begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
`ifdef SERIAL_TO_BYTE_PARITY_EN
            r_perr  <= (^r_shift) ^ bus.bit_in;
`endif
            r_shift <= '0;
            r_state <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.bit_count  = r_count;
`ifdef SERIAL_TO_BYTE_PARITY_EN
  assign bus.parity_err = r_perr;
`endif
endmodule

// File: tb/tb_serial_to_byte.sv
// Directed bench for serial_to_byte (WIDTH=8): vector table plus reset/parity sequences.
module tb_serial_to_byte;
  logic Clk;
  logic Rst_n;

  serial_to_byte_if #(.WIDTH(8)) bus ();

  serial_to_byte #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       b;
    logic       v;
    logic       f;
    logic [7:0] exp_data;
    logic       exp_dv;
    logic       exp_busy;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic b, input logic v, input logic f, input logic [7:0] d,
                         input logic dv, input logic bz, input logic [3:0] c);
    vec_t e;
    e.b = b; e.v = v; e.f = f;
    e.exp_data = d; e.exp_dv = dv; e.exp_busy = bz; e.exp_cnt = c;
    tbl.push_back(e);
  endtask

  // One word LSB first, with optional 3-cycle gaps after bit counts ga and gb (0 = none).
  task automatic add_word(input logic [7:0] w, input int ga, input int gb, input logic [7:0] prev);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) add_vec(w[i], 1'b1, 1'b0, prev, 1'b0, 1'b1, 4'(i + 1));
      else       add_vec(w[i], 1'b1, 1'b0, w,    1'b1, 1'b0, 4'd0);
      if ((i + 1 == ga) || (i + 1 == gb))
        for (int g = 0; g < 3; g++) add_vec(1'b1, 1'b0, 1'b0, prev, 1'b0, 1'b1, 4'(i + 1));
    end
  endtask

  task automatic step(input logic b, input logic v, input logic f);
    @(negedge Clk);
    bus.bit_in = b; bus.bit_valid = v; bus.flush = f;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic dv,
                            input logic bz, input logic [3:0] c);
    check({tag, ".data_out"},   32'(bus.data_out),   32'(d));
    check({tag, ".data_valid"}, 32'(bus.data_valid), 32'(dv));
    check({tag, ".busy"},       32'(bus.busy),       32'(bz));
    check({tag, ".bit_count"},  32'(bus.bit_count),  32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.flush = 1'b0;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 4'd0);
`ifdef SERIAL_TO_BYTE_PARITY_EN
    check("reset.parity_err", 32'(bus.parity_err), 32'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;

`ifndef SERIAL_TO_BYTE_PARITY_EN
    // 0x0A with gaps after bits 2 and 5, then a clean 0x0A, then an idle cycle.
    add_word(8'h0A, 2, 5, 8'h00);
    add_word(8'h0A, 0, 0, 8'h0A);
    add_vec(1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 4'd0);
    // Back-to-back 0xA5 then 0x3C with bit_valid held high.
    add_word(8'hA5, 0, 0, 8'h0A);
    add_word(8'h3C, 0, 0, 8'hA5);
    add_vec(1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0);
    // Partial 0xFF, flush with a valid bit (dropped), then 0x81.
    for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 4'(i + 1));
    add_vec(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd0);
    add_word(8'h81, 0, 0, 8'h3C);
    add_vec(1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 4'd0);

    foreach (tbl[k]) begin
      step(tbl[k].b, tbl[k].v, tbl[k].f);
      check_outs($sformatf("vec%0d", k), tbl[k].exp_data, tbl[k].exp_dv,
                 tbl[k].exp_busy, tbl[k].exp_cnt);
    end

    // Asynchronous reset mid-cycle after 5 bits of 0x77.
    begin
      logic [7:0] w;
      w = 8'h77;
      for (int i = 0; i < 5; i++) step(w[i], 1'b1, 1'b0);
      check_outs("pre_rst", 8'h81, 1'b0, 1'b1, 4'd5);
      #2;
      Rst_n = 1'b0;
      #1;
      check_outs("async_rst", 8'h00, 1'b0, 1'b0, 4'd0);
      @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      bus.bit_valid = 1'b0;
      w = 8'h12;
      for (int i = 0; i < 7; i++) step(w[i], 1'b1, 1'b0);
      check_outs("post_rst7", 8'h00, 1'b0, 1'b1, 4'd7);
      step(w[7], 1'b1, 1'b0);
      check_outs("post_rst8", 8'h12, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b0, 1'b0);
      check_outs("post_rst_idle", 8'h12, 1'b0, 1'b0, 4'd0);
    end
`else
    begin
      logic [7:0] w;
      // 0x0A + parity 0 -> even parity holds.
      w = 8'h0A;
      for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b0);
      check_outs("par0_8", 8'h00, 1'b0, 1'b1, 4'd8);
      step(1'b0, 1'b1, 1'b0);
      check_outs("par0_9", 8'h0A, 1'b1, 1'b0, 4'd0);
      check("par0.parity_err", 32'(bus.parity_err), 32'd0);
      // 0x0B + parity 0 -> three ones, parity error.
      w = 8'h0B;
      for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b0);
      check_outs("par1_8", 8'h0A, 1'b0, 1'b1, 4'd8);
      step(1'b0, 1'b1, 1'b0);
      check_outs("par1_9", 8'h0B, 1'b1, 1'b0, 4'd0);
      check("par1.parity_err", 32'(bus.parity_err), 32'd1);
      // Flush while awaiting parity: word dropped, parity_err held.
      w = 8'h0A;
      for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check_outs("par_flush", 8'h0B, 1'b0, 1'b0, 4'd0);
      check("par_flush.parity_err", 32'(bus.parity_err), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
